// File: rtl/sr_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_pulse_driver
// Brief    : Debounces two raw push-buttons and issues clean, mutually
//            exclusive, fixed-width active-low set/reset pulses to an SR latch.
// Revision : 1.0
// ============================================================================
module sr_pulse_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic latch_set_n,
  output logic latch_reset_n,
  output logic busy
);

  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_PW_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PW_W-1:0] c_PW_LAST = c_PW_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PULSE_SET   = 2'd1,
    S_PULSE_RESET = 2'd2,
    S_GAP         = 2'd3
  } state_t;

  // Channel index 0 is the set button, index 1 the reset button.
  logic [1:0] w_btn;
  logic [1:0] w_pend_eff;
  logic [1:0] w_take;

  assign w_btn = {btn_reset, btn_set};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      logic              r_sync1;
      logic              r_sync2;
      logic              r_deb;
      logic              r_deb_d;
      logic [c_DB_W-1:0] r_cnt;
      logic              r_pend;
      logic              w_req;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_btn[g];
          r_sync2 <= r_sync1;
          r_deb_d <= r_deb;
          // Any sample that agrees with the current level restarts the count.
          if (r_sync2 != r_deb) begin
            if (r_cnt == c_DB_LAST) begin
              r_deb <= ~r_deb;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end

      assign w_req         = r_deb & ~r_deb_d;
      assign w_pend_eff[g] = r_pend | w_req;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_pend <= 1'b0;
        end else begin
          r_pend <= w_take[g] ? 1'b0 : w_pend_eff[g];
        end
      end
    end
  endgenerate

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_PW_W-1:0] r_pcnt;
  logic [c_PW_W-1:0] w_pcnt_nxt;
  logic              r_set_n;
  logic              r_reset_n;
  logic              r_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_take      = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_pend_eff[1]) begin
          w_state_nxt = S_PULSE_RESET;
          w_take      = 2'b10;
          w_pcnt_nxt  = '0;
        end else if (w_pend_eff[0]) begin
          w_state_nxt = S_PULSE_SET;
          w_take      = 2'b01;
          w_pcnt_nxt  = '0;
        end
      end
      S_PULSE_SET, S_PULSE_RESET: begin
        if (r_pcnt == c_PW_LAST) begin
          w_state_nxt = S_GAP;
          w_pcnt_nxt  = '0;
        end else begin
          w_pcnt_nxt = r_pcnt + 1'b1;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pcnt_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge
  // as the state register, keeping both pulses registered and glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pcnt    <= '0;
      r_set_n   <= 1'b1;
      r_reset_n <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_set_n   <= (w_state_nxt != S_PULSE_SET);
      r_reset_n <= (w_state_nxt != S_PULSE_RESET);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign latch_set_n   = r_set_n;
  assign latch_reset_n = r_reset_n;
  assign busy          = r_busy;

endmodule
`default_nettype wire
